// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite constants and the initiator state encoding.
package axi_lite_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned RESP_W = 2;
   localparam int unsigned PROT_W = 3;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT_B,
      READ,
      WAIT_R,
      RESP
   } state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-lite bus between one initiator and one register slave.
// master: drives AW/W/AR payload+valid and B/R ready; slave: the reverse.
interface axi_lite_master_if
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 11
);

   logic [ADDRESS_WIDTH-1:0] awaddr;
   logic [PROT_W-1:0]        awprot;
   logic                     awvalid;
   logic                     awready;
   logic [DATA_W-1:0]        wdata;
   logic [STRB_W-1:0]        wstrb;
   logic                     wvalid;
   logic                     wready;
   logic [RESP_W-1:0]        bresp;
   logic                     bvalid;
   logic                     bready;
   logic [ADDRESS_WIDTH-1:0] araddr;
   logic [PROT_W-1:0]        arprot;
   logic                     arvalid;
   logic                     arready;
   logic [DATA_W-1:0]        rdata;
   logic [RESP_W-1:0]        rresp;
   logic                     rvalid;
   logic                     rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite initiator: turns one valid/ready register command
// into an AXI4-lite read or write and returns the slave response, with a
// watchdog that forces an SLVERR response if the slave stalls too long.
// Ports:
//   clk_i, reset_ni          clock, async active-low reset
//   cmd_*                    command request (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                    response (valid/ready, rdata, resp, timeout flag)
//   m_axi                    AXI4-lite master port (axi_lite_master_if.master)
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = 11,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_write_i,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0]        cmd_wdata_i,
   input  logic [STRB_W-1:0]        cmd_wstrb_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_W-1:0]        rsp_rdata_o,
   output logic [RESP_W-1:0]        rsp_resp_o,
   output logic                     rsp_timeout_o,
   axi_lite_master_if.master        m_axi
);

   // A zero timeout still needs a 1-bit counter to keep the declarations legal.
   localparam int unsigned TIMEOUT_W =
      (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMEOUT_W-1:0] WD_LAST =
      TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_e               state_q;
   logic [TIMEOUT_W-1:0] wd_q;
   logic                 active_c;
   logic                 phase_done_c;
   logic                 wd_expire_c;

   assign m_axi.awprot = '0;
   assign m_axi.arprot = '0;

   // Phase completion seen this cycle; a handshake here beats watchdog expiry.
   always_comb begin
      phase_done_c = 1'b0;
      active_c     = 1'b1;
      unique case (state_q)
         WRITE:   phase_done_c = (!m_axi.awvalid || m_axi.awready) &&
                                 (!m_axi.wvalid  || m_axi.wready);
         WAIT_B:  phase_done_c = m_axi.bvalid;
         READ:    phase_done_c = m_axi.arready;
         WAIT_R:  phase_done_c = m_axi.rvalid;
         default: active_c     = 1'b0;
      endcase
   end

   assign wd_expire_c = (TIMEOUT_CYCLES != 0) && (wd_q >= WD_LAST);

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= IDLE;
         wd_q          <= '0;
         cmd_ready_o   <= 1'b1;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_resp_o    <= RESP_OKAY;
         rsp_timeout_o <= 1'b0;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wstrb   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
      end else if (active_c && !phase_done_c && wd_expire_c) begin
         // Abandon the slave; any late response it produces is ignored.
         state_q       <= RESP;
         m_axi.awvalid <= 1'b0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
         rsp_valid_o   <= 1'b1;
         rsp_rdata_o   <= '0;
         rsp_resp_o    <= RESP_SLVERR;
         rsp_timeout_o <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  cmd_ready_o   <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  wd_q          <= '0;
                  if (cmd_write_i) begin
                     state_q       <= WRITE;
                     m_axi.awaddr  <= cmd_addr_i;
                     m_axi.wdata   <= cmd_wdata_i;
                     m_axi.wstrb   <= cmd_wstrb_i;
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                  end else begin
                     state_q       <= READ;
                     m_axi.araddr  <= cmd_addr_i;
                     m_axi.arvalid <= 1'b1;
                  end
               end
            end
            WRITE: begin
               wd_q <= wd_q + TIMEOUT_W'(1);
               // AW and W retire independently; move on once both are done.
               if (phase_done_c) begin
                  state_q       <= WAIT_B;
                  m_axi.awvalid <= 1'b0;
                  m_axi.wvalid  <= 1'b0;
                  m_axi.bready  <= 1'b1;
               end else begin
                  m_axi.awvalid <= m_axi.awvalid && !m_axi.awready;
                  m_axi.wvalid  <= m_axi.wvalid && !m_axi.wready;
               end
            end
            WAIT_B: begin
               wd_q <= wd_q + TIMEOUT_W'(1);
               if (phase_done_c) begin
                  state_q      <= RESP;
                  m_axi.bready <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_rdata_o  <= '0;
                  rsp_resp_o   <= m_axi.bresp;
               end
            end
            READ: begin
               wd_q <= wd_q + TIMEOUT_W'(1);
               if (phase_done_c) begin
                  state_q       <= WAIT_R;
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
               end
            end
            WAIT_R: begin
               wd_q <= wd_q + TIMEOUT_W'(1);
               if (phase_done_c) begin
                  state_q      <= RESP;
                  m_axi.rready <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_rdata_o  <= m_axi.rdata;
                  rsp_resp_o   <= m_axi.rresp;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small delay-programmable
// AXI4-lite register slave (16 words at 0x000-0x03C, SLVERR above).
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [10:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_wstrb_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_timeout_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_resp_o;

   int checks = 0;
   int errors = 0;

   axi_lite_master_if #(.ADDRESS_WIDTH(11)) bus ();

   axi_lite_master #(.ADDRESS_WIDTH(11), .TIMEOUT_CYCLES(16)) dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_write_i  (cmd_write_i),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_wdata_i  (cmd_wdata_i),
      .cmd_wstrb_i  (cmd_wstrb_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_resp_o   (rsp_resp_o),
      .rsp_timeout_o(rsp_timeout_o),
      .m_axi        (bus.master)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- slave model ----------------
   // Delay -1 means the slave never responds on that channel.
   int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic slv_flush = 1'b0;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic aw_got, w_got, b_busy, r_busy;
   logic [10:0] aw_a;
   logic [31:0] w_d;
   logic [3:0]  w_s;
   logic [31:0] mem [16];
   int wr_count = 0;

   assign bus.awready = bus.awvalid && (aw_dly >= 0) && (aw_cnt >= aw_dly);
   assign bus.wready  = bus.wvalid  && (w_dly  >= 0) && (w_cnt  >= w_dly);
   assign bus.arready = bus.arvalid && (ar_dly >= 0) && (ar_cnt >= ar_dly);

   logic aw_now, w_now, ar_now, commit;
   logic [10:0] wa;
   logic [31:0] wdv;
   logic [3:0]  wsv;
   assign aw_now = bus.awvalid && bus.awready;
   assign w_now  = bus.wvalid && bus.wready;
   assign ar_now = bus.arvalid && bus.arready;
   assign wa     = aw_got ? aw_a : bus.awaddr;
   assign wdv    = w_got ? w_d : bus.wdata;
   assign wsv    = w_got ? w_s : bus.wstrb;
   assign commit = (aw_got || aw_now) && (w_got || w_now) && !b_busy && !slv_flush;

   always @(posedge clk_i) begin
      if (!reset_ni) begin
         for (int i = 0; i < 16; i++)
            mem[i] <= (i == 0) ? 32'h0004_0069 : (32'hA5A5_0000 | 32'(i));
         wr_count <= 0;
      end else if (commit) begin
         wr_count <= wr_count + 1;
         if (wa < 11'h040)
            for (int b = 0; b < 4; b++)
               if (wsv[b]) mem[wa[5:2]][8*b +: 8] <= wdv[8*b +: 8];
      end
   end

   always @(posedge clk_i) begin
      if (!reset_ni || slv_flush) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_busy <= 1'b0; r_busy <= 1'b0;
         aw_a <= '0; w_d <= '0; w_s <= '0;
         bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
         bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
      end else begin
         aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus.wvalid  && !bus.wready)  ? w_cnt + 1  : 0;
         ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
         if (commit) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            b_busy <= 1'b1; b_cnt <= 1;
            bus.bvalid <= (b_dly == 0);
            bus.bresp  <= (wa < 11'h040) ? 2'b00 : 2'b10;
         end else begin
            if (aw_now) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
            if (w_now)  begin w_got <= 1'b1; w_d <= bus.wdata; w_s <= bus.wstrb; end
         end
         if (b_busy) begin
            if (bus.bvalid && bus.bready) begin
               bus.bvalid <= 1'b0; b_busy <= 1'b0;
            end else if (!bus.bvalid) begin
               if (b_dly >= 0 && b_cnt >= b_dly) bus.bvalid <= 1'b1;
               else b_cnt <= b_cnt + 1;
            end
         end
         if (ar_now && !r_busy) begin
            r_busy <= 1'b1; r_cnt <= 1;
            bus.rvalid <= (r_dly == 0);
            bus.rdata  <= (bus.araddr < 11'h040) ? mem[bus.araddr[5:2]] : 32'h0;
            bus.rresp  <= (bus.araddr < 11'h040) ? 2'b00 : 2'b10;
         end else if (r_busy) begin
            if (bus.rvalid && bus.rready) begin
               bus.rvalid <= 1'b0; r_busy <= 1'b0;
            end else if (!bus.rvalid) begin
               if (r_dly >= 0 && r_cnt >= r_dly) bus.rvalid <= 1'b1;
               else r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // ---------------- bus monitor ----------------
   int aw_hs = 0, w_hs = 0, arv_cyc = 0, acc_cnt = 0, viol = 0;
   logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
   logic [10:0] p_awaddr, p_araddr;
   logic [31:0] p_wdata;
   logic [3:0]  p_wstrb;

   always @(posedge clk_i) begin
      if (aw_now) aw_hs <= aw_hs + 1;
      if (w_now)  w_hs  <= w_hs + 1;
      if (bus.arvalid) arv_cyc <= arv_cyc + 1;
      if (cmd_valid_i && cmd_ready_o) acc_cnt <= acc_cnt + 1;
      if ((p_aw && bus.awvalid && bus.awaddr !== p_awaddr) ||
          (p_w  && bus.wvalid  && (bus.wdata !== p_wdata || bus.wstrb !== p_wstrb)) ||
          (p_ar && bus.arvalid && bus.araddr !== p_araddr))
         viol <= viol + 1;
      p_aw <= bus.awvalid && !bus.awready;
      p_w  <= bus.wvalid  && !bus.wready;
      p_ar <= bus.arvalid && !bus.arready;
      p_awaddr <= bus.awaddr; p_araddr <= bus.araddr;
      p_wdata  <= bus.wdata;  p_wstrb  <= bus.wstrb;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_d, w_d, ar_d, b_d, r_d;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      logic        exp_to;
      int          exp_lat;
      int          exp_wr;
      int          exp_arv;
   } vec_t;

   function automatic vec_t mk(logic wr, logic [10:0] a, logic [31:0] d, logic [3:0] s,
                               int awd, int wd, int ard, int bd, int rd,
                               logic [31:0] er, logic [1:0] es, logic et,
                               int el, int ew, int ea);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
      v.aw_d = awd; v.w_d = wd; v.ar_d = ard; v.b_d = bd; v.r_d = rd;
      v.exp_rdata = er; v.exp_resp = es; v.exp_to = et;
      v.exp_lat = el; v.exp_wr = ew; v.exp_arv = ea;
      return v;
   endfunction

   // Issue one command, measure cycles from accept to rsp_valid, consume it.
   task automatic run_vec(input vec_t v, input string tag, output logic [31:0] rd,
                          output logic [1:0] rs, output logic to, output int lat);
      int n;
      @(negedge clk_i);
      aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d; b_dly = v.b_d; r_dly = v.r_d;
      cmd_write_i = v.wr; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata; cmd_wstrb_i = v.wstrb;
      cmd_valid_i = 1'b1;
      n = 0;
      while (!cmd_ready_o && n < 50) begin @(negedge clk_i); n++; end
      chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 100) begin @(negedge clk_i); lat++; end
      rd = rsp_rdata_o; rs = rsp_resp_o; to = rsp_timeout_o;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      slv_flush = 1'b1;
      @(negedge clk_i);
      slv_flush = 1'b0;
   endtask

   vec_t vecs [17];

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        to;
      int lat, a0, w0, ar0, wr0, acc0, n;
      string tag;

      vecs[0]  = mk(1, 11'h01C, 32'h0000_0005, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3, 1, 0);
      vecs[1]  = mk(0, 11'h000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0004_0069, 2'b00, 0, 3, 0, 1);
      vecs[2]  = mk(0, 11'h01C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0000_0005, 2'b00, 0, 3, 0, 1);
      vecs[3]  = mk(1, 11'h008, 32'h1122_3344, 4'h5, 3, 0, 0, 0, 0, 32'h0, 2'b00, 0, 6, 1, 0);
      vecs[4]  = mk(0, 11'h008, 32'h0, 4'h0, 0, 0, 2, 0, 3, 32'hA522_0044, 2'b00, 0, 8, 0, 3);
      vecs[5]  = mk(1, 11'h040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2, 0, 32'h0, 2'b10, 0, 5, 1, 0);
      vecs[6]  = mk(0, 11'h044, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 2'b10, 0, 3, 0, 1);
      vecs[7]  = mk(1, 11'h00C, 32'hCAFE_F00D, 4'hF, 1, 4, 0, 0, 0, 32'h0, 2'b00, 0, 7, 1, 0);
      vecs[8]  = mk(0, 11'h00C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 0, 3, 0, 1);
      vecs[9]  = mk(0, 11'h004, 32'h0, 4'h0, 0, 0, -1, 0, 0, 32'h0, 2'b10, 1, 17, 0, 16);
      vecs[10] = mk(0, 11'h004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hA5A5_0001, 2'b00, 0, 3, 0, 1);
      vecs[11] = mk(0, 11'h014, 32'h0, 4'h0, 0, 0, 0, 0, 14, 32'hA5A5_0005, 2'b00, 0, 17, 0, 1);
      vecs[12] = mk(0, 11'h018, 32'h0, 4'h0, 0, 0, 0, 0, 15, 32'h0, 2'b10, 1, 17, 0, 1);
      vecs[13] = mk(1, 11'h010, 32'h1234_5678, 4'hF, 0, 0, 0, -1, 0, 32'h0, 2'b10, 1, 17, 1, 0);
      vecs[14] = mk(0, 11'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 3, 0, 1);
      vecs[15] = mk(1, 11'h03C, 32'h0000_ABCD, 4'hC, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3, 1, 0);
      vecs[16] = mk(0, 11'h03C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0000_000F, 2'b00, 0, 3, 0, 1);

      reset_ni = 1'b0;
      cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
      cmd_wdata_i = '0; cmd_wstrb_i = '0; rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);

      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_awaddr", 32'(bus.awaddr), 32'd0);
      reset_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 17; i++) begin
         tag = $sformatf("v%0d", i);
         a0 = aw_hs; w0 = w_hs; ar0 = arv_cyc; wr0 = wr_count;
         run_vec(vecs[i], tag, rd, rs, to, lat);
         chk({tag, "_rdata"},   rd, vecs[i].exp_rdata);
         chk({tag, "_resp"},    32'(rs), 32'(vecs[i].exp_resp));
         chk({tag, "_timeout"}, 32'(to), 32'(vecs[i].exp_to));
         chk({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
         chk({tag, "_aw_hs"},   32'(aw_hs - a0), 32'(vecs[i].exp_wr));
         chk({tag, "_w_hs"},    32'(w_hs - w0), 32'(vecs[i].exp_wr));
         chk({tag, "_commits"}, 32'(wr_count - wr0), 32'(vecs[i].exp_wr));
         chk({tag, "_arvalid_cycles"}, 32'(arv_cyc - ar0), 32'(vecs[i].exp_arv));
      end

      // Response back-pressure with cmd_valid held high throughout.
      @(negedge clk_i);
      aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
      cmd_write_i = 1'b1; cmd_addr_i = 11'h020; cmd_wdata_i = 32'h77; cmd_wstrb_i = 4'hF;
      acc0 = acc_cnt;
      cmd_valid_i = 1'b1;
      n = 0;
      while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
      chk("bp_rsp_seen", 32'(rsp_valid_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid_o), 32'd1);
         chk($sformatf("bp_hold%0d_cmd_ready", i), 32'(cmd_ready_o), 32'd0);
         chk($sformatf("bp_hold%0d_resp", i), {rsp_rdata_o[29:0], rsp_resp_o}, 32'd0);
         @(negedge clk_i);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("bp_cmd_ready_after", 32'(cmd_ready_o), 32'd1);
      chk("bp_rsp_valid_after", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      chk("bp_accepts", 32'(acc_cnt - acc0), 32'd2);
      n = 0;
      while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
      chk("bp_second_rsp", {29'd0, rsp_timeout_o, rsp_resp_o}, 32'd0);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      slv_flush = 1'b1;
      @(negedge clk_i);
      slv_flush = 1'b0;

      chk("axi_payload_stable", 32'(viol), 32'd0);

      // Asynchronous reset while waiting for read data.
      @(negedge clk_i);
      ar_dly = 0; r_dly = -1;
      cmd_write_i = 1'b0; cmd_addr_i = 11'h000; cmd_valid_i = 1'b1;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      n = 0;
      while (!bus.rready && n < 50) begin @(negedge clk_i); n++; end
      chk("ar_rst_in_wait_r", 32'(bus.rready), 32'd1);
      #2 reset_ni = 1'b0;
      #1;
      chk("ar_rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
      chk("ar_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("ar_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      @(negedge clk_i);
      reset_ni = 1'b1;
      run_vec(vecs[1], "post_rst", rd, rs, to, lat);
      chk("post_rst_rdata", rd, 32'h0004_0069);
      chk("post_rst_latency", 32'(lat), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
